compositor_blend_stage: RTL and testbench
=========================================

# compositor_blend_stage

Parametrised three-stage pixel compositing stage that merges one background pixel and one already-fetched foreground pixel per clock into an RGB565 output pixel. It sits after the foreground fetch path and before the output formatter. It generalises the fixed-resolution overlay path in three ways:
- resolution and transparency precision are parameters;
- it adds chroma-key and alpha-blend modes;
- control registers are latched at frame start so mid-frame register writes never tear.

## Interface
Parameters:
- PRECISION, 12, width of pixel coordinate and clip ports
- RESOLUTION_X, 1920, active pixels per line
- RESOLUTION_Y, 1080, active lines per frame
- TRANSPARENCY_PRECISION, 3, fractional bits of opacity; full opacity = 2^TRANSPARENCY_PRECISION

Ports:
- clk  in  1  single clock for all logic
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  a pixel pair is present this cycle
- in_x, in_y  in  PRECISION  coordinate of the pixel pair
- in_blank  in  1  pixel lies in the blanking area
- bg_pixel  in  16  background pixel, RGB565
- fg_pixel  in  16  foreground pixel, RGB565
- fg_skip  in  1  no foreground pixel exists at this coordinate
- ctrl_mode  in  2  00 bg only, 01 overlay, 10 chroma key, 11 alpha blend
- ctrl_opacity  in  TRANSPARENCY_PRECISION+1  foreground weight
- ctrl_key_color  in  16  chroma-key colour
- ctrl_clip_left, ctrl_clip_right, ctrl_clip_top, ctrl_clip_bottom  in  PRECISION  pixels of foreground removed from each screen edge
- pixel_out  out  16  composited pixel
- pixel_x_out, pixel_y_out  out  PRECISION  coordinate of pixel_out
- pixel_ready_out  out  1  pixel_out is valid

## Operation
Control latching:
- Active copies of every ctrl_* input are loaded when in_valid=1, in_x=0 and in_y=0, i.e. on the frame-start pixel.
- The frame-start pixel itself uses the newly loaded values.
- All other pixels use the copies held since the last frame start.
- After reset the active copies are: mode 00, opacity 0, key 0x0000, all clips 0.
- The active opacity is clamped to 2^TRANSPARENCY_PRECISION when loaded.

Foreground visibility: fg_vis = !fg_skip && !in_blank && x >= clip_left && x < RESOLUTION_X − clip_right && y >= clip_top && y < RESOLUTION_Y − clip_bottom.
- Compare at PRECISION+1 bits.
- If clip_left + clip_right >= RESOLUTION_X, no pixel on the line is visible; the same rule applies vertically.

Mode results:
- in_blank=1: output 0x0000 in every mode.
- 00: bg.
- 01: fg if fg_vis, else bg.
- 10: fg if fg_vis and fg != key, else bg.
- 11: if fg_vis, blend per channel, else bg.

Blend arithmetic, with A = opacity and F = 2^TRANSPARENCY_PRECISION:
- out_c = (fg_c·A + bg_c·(F−A)) >> TRANSPARENCY_PRECISION, computed separately for R (5b), G (6b) and B (5b).
- Intermediates are 6+TRANSPARENCY_PRECISION+1 bits; no overflow is possible.
- Truncate, never round.
- A=F returns fg exactly; A=0 returns bg exactly.

Pipeline stages:
- S1: register the inputs, latch controls, compute fg_vis and the key match.
- S2: per-channel multiplies and add.
- S3: shift, select by mode, pack, drive the outputs.

Coordinates and valid travel alongside the data unchanged.

## Timing
- Latency is exactly 3 cycles from in_valid to pixel_ready_out, with a throughput of one pixel per cycle and no stalls or backpressure.
- pixel_ready_out equals in_valid delayed by 3 cycles; gaps in in_valid reproduce as gaps in the output.
- While pixel_ready_out=0, pixel_out, pixel_x_out and pixel_y_out hold their last values.
- Reset values: pixel_out=0, pixel_x_out=0, pixel_y_out=0, pixel_ready_out=0, and all stage valid bits cleared.
- Reset mid-frame: pixels in flight are discarded and pixel_ready_out is low on the first cycle after rst_n is sampled low. The first valid output is 3 cycles after the first in_valid once rst_n=1, and control copies hold reset values until the next frame-start pixel.
- A ctrl change in the cycle of the frame-start pixel takes effect for that pixel. A change at any other time takes effect at the next frame start.
- Coordinates beyond RESOLUTION_X−1 or RESOLUTION_Y−1 are treated as not visible; the output is bg, or 0 if in_blank.

## Test plan
- Reset then a stream of 8 pixels, mode 00, bg=0x1234: pixel_ready_out rises 3 cycles after the first in_valid, every pixel_out is 0x1234, and coordinates match the inputs in order.
- Mode 11, opacity 4 (half), fg=0xF800, bg=0x001F, frame-start pixel: output 0x780F. Opacity 8 gives 0xF800; opacity 15 is clamped and also gives 0xF800.
- Mode 10, key 0x07E0: fg=0x07E0 outputs bg; fg=0x07E1 outputs fg; fg_skip=1 outputs bg.
- Mode 01, clip_left=100, clip_right=100: x=99 gives bg, x=100 gives fg, x=1819 gives fg, x=1820 gives bg. clip_left=clip_right=960 makes the whole line bg.
- Change ctrl_mode from 00 to 01 at pixel (5,0): pixels keep mode 00 until the next (0,0) pixel, which switches to fg output. in_blank=1 pixels output 0x0000.
- rst_n low for 1 cycle with 2 pixels in flight: neither pixel is emitted, outputs return to their reset values, and the active mode is 00 until the next frame start.

Source files
------------

// File: rtl/compositor_blend_stage.sv
// ============================================================================
// compositor_blend_stage
// Three-stage RGB565 compositor: bg only, overlay, chroma key and alpha blend.
// Revision: 1.0
// ============================================================================
`default_nettype none

module compositor_blend_stage #(
  parameter int PRECISION              = 12,
  parameter int RESOLUTION_X           = 1920,
  parameter int RESOLUTION_Y           = 1080,
  parameter int TRANSPARENCY_PRECISION = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [PRECISION-1:0]          in_x,
  input  logic [PRECISION-1:0]          in_y,
  input  logic                          in_blank,
  input  logic [15:0]                   bg_pixel,
  input  logic [15:0]                   fg_pixel,
  input  logic                          fg_skip,
  input  logic [1:0]                    ctrl_mode,
  input  logic [TRANSPARENCY_PRECISION:0] ctrl_opacity,
  input  logic [15:0]                   ctrl_key_color,
  input  logic [PRECISION-1:0]          ctrl_clip_left,
  input  logic [PRECISION-1:0]          ctrl_clip_right,
  input  logic [PRECISION-1:0]          ctrl_clip_top,
  input  logic [PRECISION-1:0]          ctrl_clip_bottom,
  output logic [15:0]                   pixel_out,
  output logic [PRECISION-1:0]          pixel_x_out,
  output logic [PRECISION-1:0]          pixel_y_out,
  output logic                          pixel_ready_out
);

  localparam int TP = TRANSPARENCY_PRECISION;
  localparam int AW = TP + 1;
  localparam int W  = PRECISION + 1;
  localparam int BW = 6 + TP + 1;
  localparam logic [AW-1:0] FULL  = AW'(1 << TP);
  localparam logic [W-1:0]  RES_X = W'(RESOLUTION_X);
  localparam logic [W-1:0]  RES_Y = W'(RESOLUTION_Y);

  localparam logic [1:0] MODE_BG    = 2'b00;
  localparam logic [1:0] MODE_OVL   = 2'b01;
  localparam logic [1:0] MODE_KEY   = 2'b10;

  localparam logic [1:0] SEL_ZERO  = 2'd0;
  localparam logic [1:0] SEL_BG    = 2'd1;
  localparam logic [1:0] SEL_FG    = 2'd2;
  localparam logic [1:0] SEL_BLEND = 2'd3;

  // Active control copies, refreshed only on the frame-start pixel
  logic [1:0]           act_mode;
  logic [AW-1:0]        act_opacity;
  logic [15:0]          act_key;
  logic [PRECISION-1:0] act_clip_l, act_clip_r, act_clip_t, act_clip_b;

  logic                 frame_start;
  logic [AW-1:0]        opacity_clamped;
  logic [1:0]           eff_mode;
  logic [AW-1:0]        eff_opacity;
  logic [15:0]          eff_key;
  logic [PRECISION-1:0] eff_clip_l, eff_clip_r, eff_clip_t, eff_clip_b;
  logic [W-1:0]         lr_sum, tb_sum, x_lim, y_lim, x_ext, y_ext;
  logic                 x_ok, y_ok, fg_vis, key_match;
  logic [1:0]           sel;

  always_comb begin
    frame_start     = in_valid && (in_x == '0) && (in_y == '0);
    opacity_clamped = (ctrl_opacity > FULL) ? FULL : ctrl_opacity;
    eff_mode        = frame_start ? ctrl_mode        : act_mode;
    eff_opacity     = frame_start ? opacity_clamped  : act_opacity;
    eff_key         = frame_start ? ctrl_key_color   : act_key;
    eff_clip_l      = frame_start ? ctrl_clip_left   : act_clip_l;
    eff_clip_r      = frame_start ? ctrl_clip_right  : act_clip_r;
    eff_clip_t      = frame_start ? ctrl_clip_top    : act_clip_t;
    eff_clip_b      = frame_start ? ctrl_clip_bottom : act_clip_b;

    // Sum guard makes the subtraction below safe against underflow
    lr_sum = {1'b0, eff_clip_l} + {1'b0, eff_clip_r};
    tb_sum = {1'b0, eff_clip_t} + {1'b0, eff_clip_b};
    x_lim  = RES_X - {1'b0, eff_clip_r};
    y_lim  = RES_Y - {1'b0, eff_clip_b};
    x_ext  = {1'b0, in_x};
    y_ext  = {1'b0, in_y};
    x_ok   = (lr_sum < RES_X) && (x_ext >= {1'b0, eff_clip_l}) && (x_ext < x_lim);
    y_ok   = (tb_sum < RES_Y) && (y_ext >= {1'b0, eff_clip_t}) && (y_ext < y_lim);
    fg_vis    = !fg_skip && !in_blank && x_ok && y_ok;
    key_match = (fg_pixel == eff_key);

    sel = SEL_BG;
    if (in_blank) begin
      sel = SEL_ZERO;
    end else begin
      case (eff_mode)
        MODE_BG:  sel = SEL_BG;
        MODE_OVL: sel = fg_vis ? SEL_FG : SEL_BG;
        MODE_KEY: sel = (fg_vis && !key_match) ? SEL_FG : SEL_BG;
        default:  sel = fg_vis ? SEL_BLEND : SEL_BG;
      endcase
    end
  end

  logic                 s1_valid, s2_valid;
  logic [PRECISION-1:0] s1_x, s1_y, s2_x, s2_y;
  logic [1:0]           s1_sel, s2_sel;
  logic [15:0]          s1_bg, s1_fg, s2_bg, s2_fg;
  logic [AW-1:0]        s1_opacity, inv_opacity;
  logic [BW-1:0]        blend_r, blend_g, blend_b;
  logic [BW-1:0]        s2_sum_r, s2_sum_g, s2_sum_b;

  always_comb begin
    inv_opacity = FULL - s1_opacity;
    blend_r = BW'(s1_fg[15:11]) * BW'(s1_opacity) + BW'(s1_bg[15:11]) * BW'(inv_opacity);
    blend_g = BW'(s1_fg[10:5])  * BW'(s1_opacity) + BW'(s1_bg[10:5])  * BW'(inv_opacity);
    blend_b = BW'(s1_fg[4:0])   * BW'(s1_opacity) + BW'(s1_bg[4:0])   * BW'(inv_opacity);
  end

  logic [15:0] blended, result;
  logic        unused_blend_bits;

  always_comb begin
    blended = {s2_sum_r[TP +: 5], s2_sum_g[TP +: 6], s2_sum_b[TP +: 5]};
    case (s2_sel)
      SEL_ZERO: result = 16'h0000;
      SEL_BG:   result = s2_bg;
      SEL_FG:   result = s2_fg;
      default:  result = blended;
    endcase
  end

  // Fraction and headroom bits of the sums never reach the output
  assign unused_blend_bits = ^{s2_sum_r, s2_sum_g, s2_sum_b};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act_mode        <= MODE_BG;
      act_opacity     <= '0;
      act_key         <= 16'h0000;
      act_clip_l      <= '0;
      act_clip_r      <= '0;
      act_clip_t      <= '0;
      act_clip_b      <= '0;
      s1_valid        <= 1'b0;
      s2_valid        <= 1'b0;
      pixel_out       <= 16'h0000;
      pixel_x_out     <= '0;
      pixel_y_out     <= '0;
      pixel_ready_out <= 1'b0;
    end else begin
      if (frame_start) begin
        act_mode    <= ctrl_mode;
        act_opacity <= opacity_clamped;
        act_key     <= ctrl_key_color;
        act_clip_l  <= ctrl_clip_left;
        act_clip_r  <= ctrl_clip_right;
        act_clip_t  <= ctrl_clip_top;
        act_clip_b  <= ctrl_clip_bottom;
      end
      s1_valid        <= in_valid;
      s2_valid        <= s1_valid;
      pixel_ready_out <= s2_valid;
      if (s2_valid) begin
        pixel_out   <= result;
        pixel_x_out <= s2_x;
        pixel_y_out <= s2_y;
      end
    end
  end

  // Datapath registers need no reset: they are qualified by the valid bits
  always_ff @(posedge clk) begin
    s1_x       <= in_x;
    s1_y       <= in_y;
    s1_sel     <= sel;
    s1_bg      <= bg_pixel;
    s1_fg      <= fg_pixel;
    s1_opacity <= eff_opacity;
    s2_x       <= s1_x;
    s2_y       <= s1_y;
    s2_sel     <= s1_sel;
    s2_bg      <= s1_bg;
    s2_fg      <= s1_fg;
    s2_sum_r   <= blend_r;
    s2_sum_g   <= blend_g;
    s2_sum_b   <= blend_b;
  end

endmodule

`default_nettype wire

// File: tb/tb_compositor_blend_stage.sv
// ============================================================================
// tb_compositor_blend_stage
// Directed self-checking bench for compositor_blend_stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_compositor_blend_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [11:0] in_x, in_y;
  logic        in_blank;
  logic [15:0] bg_pixel, fg_pixel;
  logic        fg_skip;
  logic [1:0]  ctrl_mode;
  logic [3:0]  ctrl_opacity;
  logic [15:0] ctrl_key_color;
  logic [11:0] ctrl_clip_left, ctrl_clip_right, ctrl_clip_top, ctrl_clip_bottom;
  logic [15:0] pixel_out;
  logic [11:0] pixel_x_out, pixel_y_out;
  logic        pixel_ready_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  compositor_blend_stage #(
    .PRECISION(12), .RESOLUTION_X(1920), .RESOLUTION_Y(1080), .TRANSPARENCY_PRECISION(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_x(in_x), .in_y(in_y),
    .in_blank(in_blank), .bg_pixel(bg_pixel), .fg_pixel(fg_pixel), .fg_skip(fg_skip),
    .ctrl_mode(ctrl_mode), .ctrl_opacity(ctrl_opacity), .ctrl_key_color(ctrl_key_color),
    .ctrl_clip_left(ctrl_clip_left), .ctrl_clip_right(ctrl_clip_right),
    .ctrl_clip_top(ctrl_clip_top), .ctrl_clip_bottom(ctrl_clip_bottom),
    .pixel_out(pixel_out), .pixel_x_out(pixel_x_out), .pixel_y_out(pixel_y_out),
    .pixel_ready_out(pixel_ready_out)
  );

  // Drive one pixel, idle, and sample the outputs three cycles later
  task automatic send(input logic [11:0] x, input logic [11:0] y, input logic blank,
                      input logic [15:0] bg, input logic [15:0] fg, input logic skip,
                      output logic [15:0] po, output logic rdy);
    @(negedge clk);
    in_valid = 1'b1; in_x = x; in_y = y; in_blank = blank;
    bg_pixel = bg; fg_pixel = fg; fg_skip = skip;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    po  = pixel_out;
    rdy = pixel_ready_out;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; in_blank = 1'b0;
    bg_pixel = '0; fg_pixel = '0; fg_skip = 1'b0;
    ctrl_mode = 2'b00; ctrl_opacity = '0; ctrl_key_color = '0;
    ctrl_clip_left = '0; ctrl_clip_right = '0; ctrl_clip_top = '0; ctrl_clip_bottom = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({pixel_ready_out, pixel_out, pixel_x_out, pixel_y_out} !== 41'd0) begin
      errors++;
      $display("FAIL reset_values: got ready=%b out=%h x=%0d y=%0d, expected all zero",
               pixel_ready_out, pixel_out, pixel_x_out, pixel_y_out);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    ctrl_mode = 2'b00;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      checks++;
      if (t >= 3 && t < 11) begin
        if (pixel_ready_out !== 1'b1 || pixel_out !== 16'h1234 ||
            pixel_x_out !== 12'(t - 3) || pixel_y_out !== 12'd0) begin
          errors++;
          $display("FAIL stream_px%0d: got ready=%b out=%h x=%0d y=%0d, expected 1 1234 %0d 0",
                   t - 3, pixel_ready_out, pixel_out, pixel_x_out, pixel_y_out, t - 3);
        end
      end else if (t == 11) begin
        if (pixel_ready_out !== 1'b0 || pixel_out !== 16'h1234 || pixel_x_out !== 12'd7) begin
          errors++;
          $display("FAIL stream_hold: got ready=%b out=%h x=%0d, expected 0 1234 7",
                   pixel_ready_out, pixel_out, pixel_x_out);
        end
      end else if (pixel_ready_out !== 1'b0) begin
        errors++;
        $display("FAIL stream_latency_t%0d: got ready=%b, expected 0", t, pixel_ready_out);
      end
      if (t < 8) begin
        in_valid = 1'b1; in_x = 12'(t); in_y = 12'd0; in_blank = 1'b0;
        bg_pixel = 16'h1234; fg_pixel = 16'hABCD; fg_skip = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_blend();
    logic [15:0] po;
    logic        rdy;
    logic [3:0]  op [4]  = '{4'd4, 4'd8, 4'd15, 4'd0};
    logic [15:0] exp [4] = '{16'h780F, 16'hF800, 16'hF800, 16'h001F};
    ctrl_mode = 2'b11;
    for (int i = 0; i < 4; i++) begin
      ctrl_opacity = op[i];
      send(12'd0, 12'd0, 1'b0, 16'h001F, 16'hF800, 1'b0, po, rdy);
      checks++;
      if (po !== exp[i] || rdy !== 1'b1) begin
        errors++;
        $display("FAIL blend_op%0d: got out=%h ready=%b, expected %h ready 1", op[i], po, rdy, exp[i]);
      end
    end
  endtask

  task automatic test_chroma();
    logic [15:0] po;
    logic        rdy;
    logic [11:0] xs [3]  = '{12'd0, 12'd1, 12'd2};
    logic [15:0] fgs [3] = '{16'h07E0, 16'h07E1, 16'h07E1};
    logic        sk [3]  = '{1'b0, 1'b0, 1'b1};
    logic [15:0] exp [3] = '{16'h1111, 16'h07E1, 16'h1111};
    ctrl_mode = 2'b10; ctrl_key_color = 16'h07E0;
    for (int i = 0; i < 3; i++) begin
      send(xs[i], 12'd0, 1'b0, 16'h1111, fgs[i], sk[i], po, rdy);
      checks++;
      if (po !== exp[i]) begin
        errors++;
        $display("FAIL chroma_%0d: got out=%h, expected %h", i, po, exp[i]);
      end
    end
  endtask

  task automatic test_clip();
    logic [15:0] po;
    logic        rdy;
    logic [11:0] xs [6]   = '{12'd0, 12'd99, 12'd100, 12'd1819, 12'd1820, 12'd1919};
    logic        isfg [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [11:0] xw [3]   = '{12'd0, 12'd959, 12'd960};
    ctrl_mode = 2'b01; ctrl_clip_left = 12'd100; ctrl_clip_right = 12'd100;
    for (int i = 0; i < 6; i++) begin
      send(xs[i], 12'd0, 1'b0, 16'h2222, 16'hC0DE, 1'b0, po, rdy);
      checks++;
      if (po !== (isfg[i] ? 16'hC0DE : 16'h2222)) begin
        errors++;
        $display("FAIL clip_x%0d: got out=%h, expected %h", xs[i], po,
                 isfg[i] ? 16'hC0DE : 16'h2222);
      end
    end
    ctrl_clip_left = 12'd960; ctrl_clip_right = 12'd960;
    for (int i = 0; i < 3; i++) begin
      send(xw[i], 12'd0, 1'b0, 16'h2222, 16'hC0DE, 1'b0, po, rdy);
      checks++;
      if (po !== 16'h2222) begin
        errors++;
        $display("FAIL clip_full_x%0d: got out=%h, expected 2222", xw[i], po);
      end
    end
    // Out-of-range coordinates with no clipping
    ctrl_clip_left = '0; ctrl_clip_right = '0;
    send(12'd0, 12'd0, 1'b0, 16'h2222, 16'hC0DE, 1'b0, po, rdy);
    send(12'd1920, 12'd5, 1'b0, 16'h2222, 16'hC0DE, 1'b0, po, rdy);
    checks++;
    if (po !== 16'h2222) begin
      errors++;
      $display("FAIL clip_beyond_x: got out=%h, expected 2222", po);
    end
    send(12'd5, 12'd1080, 1'b0, 16'h2222, 16'hC0DE, 1'b0, po, rdy);
    checks++;
    if (po !== 16'h2222) begin
      errors++;
      $display("FAIL clip_beyond_y: got out=%h, expected 2222", po);
    end
  endtask

  task automatic test_ctrl_latch();
    logic [15:0] po;
    logic        rdy;
    ctrl_mode = 2'b00;
    send(12'd0, 12'd0, 1'b0, 16'h3333, 16'h4444, 1'b0, po, rdy);
    ctrl_mode = 2'b01;
    send(12'd5, 12'd0, 1'b0, 16'h3333, 16'h4444, 1'b0, po, rdy);
    checks++;
    if (po !== 16'h3333) begin
      errors++;
      $display("FAIL latch_midframe_x5: got out=%h, expected 3333", po);
    end
    send(12'd6, 12'd0, 1'b0, 16'h3333, 16'h4444, 1'b0, po, rdy);
    checks++;
    if (po !== 16'h3333) begin
      errors++;
      $display("FAIL latch_midframe_x6: got out=%h, expected 3333", po);
    end
    send(12'd0, 12'd0, 1'b0, 16'h3333, 16'h4444, 1'b0, po, rdy);
    checks++;
    if (po !== 16'h4444) begin
      errors++;
      $display("FAIL latch_frame_start: got out=%h, expected 4444", po);
    end
    send(12'd7, 12'd0, 1'b1, 16'h3333, 16'h4444, 1'b0, po, rdy);
    checks++;
    if (po !== 16'h0000 || rdy !== 1'b1) begin
      errors++;
      $display("FAIL latch_blank: got out=%h ready=%b, expected 0000 ready 1", po, rdy);
    end
  endtask

  task automatic test_midframe_reset();
    logic [15:0] po;
    logic        rdy;
    ctrl_mode = 2'b01;
    send(12'd0, 12'd0, 1'b0, 16'h001F, 16'hF800, 1'b0, po, rdy);
    @(negedge clk);
    in_valid = 1'b1; in_x = 12'd1; in_y = 12'd0; in_blank = 1'b0;
    @(negedge clk);
    in_x = 12'd2;
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({pixel_ready_out, pixel_out, pixel_x_out, pixel_y_out} !== 41'd0) begin
      errors++;
      $display("FAIL rst_flush: got ready=%b out=%h x=%0d y=%0d, expected all zero",
               pixel_ready_out, pixel_out, pixel_x_out, pixel_y_out);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (pixel_ready_out !== 1'b0) begin
        errors++;
        $display("FAIL rst_no_emit_%0d: got ready=%b, expected 0", i, pixel_ready_out);
      end
    end
    send(12'd3, 12'd0, 1'b0, 16'h001F, 16'hF800, 1'b0, po, rdy);
    checks++;
    if (po !== 16'h001F || rdy !== 1'b1 || pixel_x_out !== 12'd3) begin
      errors++;
      $display("FAIL rst_mode_default: got out=%h ready=%b x=%0d, expected 001F ready 1 x 3",
               po, rdy, pixel_x_out);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_blend();
    test_chroma();
    test_clip();
    test_ctrl_latch();
    test_midframe_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
